mem_dump_reader: RTL and testbench

Readback engine for the byte-banked unified memory (four 8-bit lanes, banks 0..3, little-endian). Where the boot-time hex preload writes lanes from `.data` images, this block reads a word range back out after a run and streams it as 32-bit words over a valid/ready interface to the bench-side host or a UART bridge. It drives a dedicated read port on `mem` and is otherwise idle, so it never disturbs the IF/EX ports.

---
 rtl/mem_dump_reader.sv | 224 ++++++++++++++++++++++
 tb/tb_mem_dump_reader.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_dump_reader.sv
// ---------------------------------------------------------------------------
// mem_dump_reader
//
// Reads a contiguous range of words back out of the byte-banked unified
// memory (four 8-bit lanes, little-endian) through a dedicated read port.
// The words are streamed over a valid/ready interface. One read is in
// flight at a time. With the sink always ready, this gives one word every
// two cycles.
//
// Optional feature: define MEM_DUMP_CHECKSUM_EN to append one extra word
// after the data. That word holds the mod-2^32 sum of all data words that
// were handshaked. io_out_last then marks only the checksum word.
//
// Ports
//   clock               system clock, rising edge
//   reset               asynchronous, active-low reset
//   io_start            one-cycle dump request, honoured only when idle
//   io_base_addr        byte address of the first word (bits [1:0] ignored)
//   io_word_count       number of data words (0 = complete with no output)
//   io_rd_en            read strobe to all four lanes
//   io_rd_addr          word index presented to all four lanes
//   io_rd_data_0..3     lane bytes, valid one cycle after io_rd_en
//   io_out_valid        io_out_data holds a word
//   io_out_ready        sink accepts the word
//   io_out_data         assembled word {lane3, lane2, lane1, lane0}
//   io_out_last         final word of the dump
//   io_busy             high from the accepted start until DONE exits
//   io_done             one-cycle completion pulse
// ---------------------------------------------------------------------------
module mem_dump_reader #(
   parameter int ADDR_W = 14
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              io_start,
   input  logic [63:0]       io_base_addr,
   input  logic [31:0]       io_word_count,
   output logic              io_rd_en,
   output logic [ADDR_W-1:0] io_rd_addr,
   input  logic [7:0]        io_rd_data_0,
   input  logic [7:0]        io_rd_data_1,
   input  logic [7:0]        io_rd_data_2,
   input  logic [7:0]        io_rd_data_3,
   output logic              io_out_valid,
   input  logic              io_out_ready,
   output logic [31:0]       io_out_data,
   output logic              io_out_last,
   output logic              io_busy,
   output logic              io_done
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_ISSUE   = 3'd1,
      S_CAPTURE = 3'd2,
      S_OUT     = 3'd3,
      S_DONE    = 3'd4
   } state_t;

   localparam logic [ADDR_W-1:0] IDX_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] index_q, index_d;
   logic [31:0]       remaining_q, remaining_d;
   logic [31:0]       data_q, data_d;
`ifdef MEM_DUMP_CHECKSUM_EN
   logic [31:0]       sum_q, sum_d;
   logic              sum_phase_q, sum_phase_d;
`endif

   // Only the word-index field of the byte address is used.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{io_base_addr[63:ADDR_W+2], io_base_addr[1:0]};

   // This is high on the final data word. The same term drives io_out_last
   // when no checksum is appended. It also stops the lookahead read.
   logic final_data;
   logic more_words;

   always_comb begin
      final_data = (remaining_q == 32'd1);
`ifdef MEM_DUMP_CHECKSUM_EN
      more_words = !sum_phase_q && !final_data;
`else
      more_words = !final_data;
`endif
   end

   // ------------------------------------------------------------------
   // State and datapath registers
   // ------------------------------------------------------------------
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         index_q     <= '0;
         remaining_q <= '0;
         data_q      <= '0;
`ifdef MEM_DUMP_CHECKSUM_EN
         sum_q       <= '0;
         sum_phase_q <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         index_q     <= index_d;
         remaining_q <= remaining_d;
         data_q      <= data_d;
`ifdef MEM_DUMP_CHECKSUM_EN
         sum_q       <= sum_d;
         sum_phase_q <= sum_phase_d;
`endif
      end
   end

   // ------------------------------------------------------------------
   // Next state
   // ------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (io_start) begin
               state_d = (io_word_count != 32'd0) ? S_ISSUE : S_DONE;
            end
         end
         S_ISSUE:   state_d = S_CAPTURE;
         S_CAPTURE: state_d = S_OUT;
         S_OUT: begin
            if (io_out_ready) begin
`ifdef MEM_DUMP_CHECKSUM_EN
               if (sum_phase_q) begin
                  state_d = S_DONE;
               end else if (final_data) begin
                  // Stay in OUT. The checksum word replaces the data word.
                  state_d = S_OUT;
               end else begin
                  state_d = S_CAPTURE;
               end
`else
               state_d = final_data ? S_DONE : S_CAPTURE;
`endif
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // Datapath updates: index, word counter, output word, checksum
   // ------------------------------------------------------------------
   always_comb begin
      index_d     = index_q;
      remaining_d = remaining_q;
      data_d      = data_q;
`ifdef MEM_DUMP_CHECKSUM_EN
      sum_d       = sum_q;
      sum_phase_d = sum_phase_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (io_start && (io_word_count != 32'd0)) begin
               index_d     = io_base_addr[ADDR_W+1:2];
               remaining_d = io_word_count;
`ifdef MEM_DUMP_CHECKSUM_EN
               sum_d       = '0;
               sum_phase_d = 1'b0;
`endif
            end
         end
         S_CAPTURE: begin
            data_d = {io_rd_data_3, io_rd_data_2, io_rd_data_1, io_rd_data_0};
         end
         S_OUT: begin
            if (io_out_ready) begin
`ifdef MEM_DUMP_CHECKSUM_EN
               if (!sum_phase_q) begin
                  sum_d = sum_q + data_q;
                  if (final_data) begin
                     data_d      = sum_q + data_q;
                     sum_phase_d = 1'b1;
                  end
               end
`endif
               if (more_words) begin
                  // The index wraps naturally at 2^ADDR_W.
                  index_d     = index_q + IDX_ONE;
                  remaining_d = remaining_q - 32'd1;
               end
            end
         end
         default: ;
      endcase
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   always_comb begin
      io_rd_en     = 1'b0;
      io_rd_addr   = index_q;
      io_out_valid = (state_q == S_OUT);
      io_out_data  = data_q;
      io_busy      = (state_q != S_IDLE);
      io_done      = (state_q == S_DONE);
`ifdef MEM_DUMP_CHECKSUM_EN
      io_out_last  = (state_q == S_OUT) && sum_phase_q;
`else
      io_out_last  = (state_q == S_OUT) && final_data;
`endif
      case (state_q)
         S_ISSUE: io_rd_en = 1'b1;
         S_OUT: begin
            // On a handshake, read the next word in the same cycle.
            // The read then lands while the FSM is in CAPTURE.
            if (io_out_ready && more_words) begin
               io_rd_en   = 1'b1;
               io_rd_addr = index_q + IDX_ONE;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_mem_dump_reader.sv
// ---------------------------------------------------------------------------
// Testbench for mem_dump_reader. A behavioural model turns each accepted
// start into a queue of expected words and read addresses. A per-cycle
// compare process checks the DUT outputs against that model.
// ---------------------------------------------------------------------------
module tb_mem_dump_reader;
   localparam int ADDR_W = 14;
   localparam int DEPTH  = 1 << ADDR_W;

   logic              clock = 1'b0;
   logic              reset = 1'b0;
   logic              io_start = 1'b0;
   logic [63:0]       io_base_addr = '0;
   logic [31:0]       io_word_count = '0;
   logic              io_rd_en;
   logic [ADDR_W-1:0] io_rd_addr;
   logic [7:0]        io_rd_data_0, io_rd_data_1, io_rd_data_2, io_rd_data_3;
   logic              io_out_valid;
   logic              io_out_ready = 1'b1;
   logic [31:0]       io_out_data;
   logic              io_out_last;
   logic              io_busy;
   logic              io_done;

   mem_dump_reader #(.ADDR_W(ADDR_W)) dut (
      .clock(clock), .reset(reset),
      .io_start(io_start), .io_base_addr(io_base_addr), .io_word_count(io_word_count),
      .io_rd_en(io_rd_en), .io_rd_addr(io_rd_addr),
      .io_rd_data_0(io_rd_data_0), .io_rd_data_1(io_rd_data_1),
      .io_rd_data_2(io_rd_data_2), .io_rd_data_3(io_rd_data_3),
      .io_out_valid(io_out_valid), .io_out_ready(io_out_ready),
      .io_out_data(io_out_data), .io_out_last(io_out_last),
      .io_busy(io_busy), .io_done(io_done)
   );

   always #5 clock = ~clock;

   // Memory model: one word per index, and one cycle of read latency.
   logic [31:0] mem_w [DEPTH];
   logic [31:0] rd_word = '0;
   always @(posedge clock) if (io_rd_en) rd_word <= mem_w[io_rd_addr];
   assign io_rd_data_0 = rd_word[7:0];
   assign io_rd_data_1 = rd_word[15:8];
   assign io_rd_data_2 = rd_word[23:16];
   assign io_rd_data_3 = rd_word[31:24];

   int checks = 0;
   int failures = 0;

   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Model state
   logic [32:0] exp_q[$];     // {last, data}
   int unsigned addr_q[$];
   logic [31:0] got_q[$];
   int          hs_cyc_q[$];
   bit          busy_exp = 0, done_exp = 0, issue_pend = 0, mon_en = 0;
   bit          rand_ready = 0, noise_en = 0;
   int          cyc = 0, start_cyc = 0, first_valid_cyc = -1, stall_seen = 0, stall = 0;

   always @(posedge clock) cyc++;

   task automatic model_clear();
      exp_q.delete(); addr_q.delete();
      busy_exp = 0; done_exp = 0; issue_pend = 0;
   endtask

   task automatic model_load(logic [63:0] base, logic [31:0] cnt);
      int unsigned idx;
      logic [31:0] sum;
      sum = '0;
      for (int unsigned i = 0; i < cnt; i++) begin
         idx = int'(((base >> 2) + 64'(i)) % 64'(DEPTH));
         addr_q.push_back(idx);
`ifdef MEM_DUMP_CHECKSUM_EN
         exp_q.push_back({1'b0, mem_w[idx]});
`else
         exp_q.push_back({(i == cnt - 1), mem_w[idx]});
`endif
         sum = sum + mem_w[idx];
      end
`ifdef MEM_DUMP_CHECKSUM_EN
      if (cnt != 0) exp_q.push_back({1'b1, sum});
`endif
   endtask

   // Compare process: checks outputs mid-cycle, then advances the model.
   always @(negedge clock) begin : mon
      bit hs, acc, rd_exp, nxt_done, nxt_busy, nxt_issue;
      logic [32:0] ent;
      if (mon_en) begin
         check("busy", io_busy, busy_exp);
         check("done", io_done, done_exp);
         hs = 0; nxt_done = 0; nxt_issue = 0;
         if (io_out_valid) begin
            if (first_valid_cyc < 0) first_valid_cyc = cyc;
            if (exp_q.size() == 0) begin
               check("spurious_valid", io_out_valid, 1'b0);
            end else begin
               ent = exp_q[0];
               check("out_data", io_out_data, ent[31:0]);
               check("out_last", io_out_last, ent[32]);
               if (io_out_ready) begin
                  hs = 1;
                  void'(exp_q.pop_front());
                  got_q.push_back(io_out_data);
                  hs_cyc_q.push_back(cyc);
                  nxt_done = ent[32];
               end else begin
                  stall_seen++;
               end
            end
         end
         rd_exp = issue_pend || (hs && addr_q.size() != 0);
         check("rd_en", io_rd_en, rd_exp);
         if (rd_exp && addr_q.size() != 0) check("rd_addr", io_rd_addr, addr_q.pop_front());
         acc = io_start && !busy_exp;
         if (acc) begin
            start_cyc = cyc;
            first_valid_cyc = -1;
            model_load(io_base_addr, io_word_count);
            if (io_word_count == 0) nxt_done = 1; else nxt_issue = 1;
         end
         nxt_busy   = acc || (busy_exp && !done_exp);
         busy_exp   = nxt_busy;
         done_exp   = nxt_done;
         issue_pend = nxt_issue;
      end
   end

   // Sink ready: a forced stall, random back-pressure, or always ready.
   always @(posedge clock) begin
      #2;
      if (stall > 0) begin
         io_out_ready = 1'b0;
         stall--;
      end else begin
         io_out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic start_dump(logic [63:0] base, logic [31:0] cnt);
      int n = 0;
      while (busy_exp && n < 1000) begin tick(); n++; end
      if (busy_exp) check("idle_timeout", busy_exp, 1'b0);
      io_base_addr  = base;
      io_word_count = cnt;
      io_start      = 1'b1;
      tick();
      io_start      = 1'b0;
      io_base_addr  = {$urandom, $urandom};
      io_word_count = $urandom;
   endtask

   task automatic wait_done();
      int n = 0;
      while ((busy_exp || exp_q.size() != 0) && n < 2000) begin
         if (noise_en && busy_exp && ($urandom_range(0, 4) == 0)) begin
            io_start      = 1'b1;
            io_base_addr  = {$urandom, $urandom};
            io_word_count = $urandom_range(0, 8);
         end else begin
            io_start = 1'b0;
         end
         tick();
         n++;
      end
      io_start = 1'b0;
      if (busy_exp || exp_q.size() != 0) check("dump_timeout", busy_exp, 1'b0);
   endtask

   task automatic apply_reset();
      mon_en = 0;
      reset  = 1'b0;
      #1;
      check("rst_rd_en", io_rd_en, 1'b0);
      check("rst_rd_addr", io_rd_addr, '0);
      check("rst_valid", io_out_valid, 1'b0);
      check("rst_last", io_out_last, 1'b0);
      check("rst_data", io_out_data, '0);
      check("rst_busy", io_busy, 1'b0);
      check("rst_done", io_done, 1'b0);
      model_clear();
      repeat (2) tick();
      reset  = 1'b1;
      mon_en = 1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      for (int i = 0; i < DEPTH; i++) mem_w[i] = $urandom;
      mem_w[16] = 32'hDEADBEEF;
      mem_w[17] = 32'h00C0FFEE;
      repeat (3) tick();
      apply_reset();

      // Directed dump with the sink always ready: data, latency, throughput
      got_q.delete(); hs_cyc_q.delete();
      start_dump(64'h40, 32'd2);
      wait_done();
`ifdef MEM_DUMP_CHECKSUM_EN
      check("d1_count", got_q.size(), 3);
      if (got_q.size() >= 3) check("d1_sum", got_q[2], 32'hDF6EBEDD);
`else
      check("d1_count", got_q.size(), 2);
`endif
      if (got_q.size() >= 2) begin
         check("d1_word0", got_q[0], 32'hDEADBEEF);
         check("d1_word1", got_q[1], 32'h00C0FFEE);
         check("d1_interval", hs_cyc_q[1] - hs_cyc_q[0], 2);
      end
      check("d1_latency", first_valid_cyc - start_cyc, 3);

      // Same dump, sink stalls for 5 cycles starting right after word 0
      got_q.delete(); stall_seen = 0;
      start_dump(64'h40, 32'd2);
      n = 0;
      while (got_q.size() < 1 && n < 50) begin tick(); n++; end
      stall = 5;
      wait_done();
      check("stall_cycles", stall_seen, 4);
      if (got_q.size() >= 2) check("stall_word1", got_q[1], 32'h00C0FFEE);
      else check("stall_count", got_q.size(), 2);

      // Index wrap at the top of the bank
      got_q.delete();
      start_dump(64'((DEPTH - 1) * 4), 32'd3);
      wait_done();
      if (got_q.size() >= 3) begin
         check("wrap_w0", got_q[0], mem_w[DEPTH-1]);
         check("wrap_w1", got_q[1], mem_w[0]);
         check("wrap_w2", got_q[2], mem_w[1]);
      end else check("wrap_count", got_q.size(), 3);

      // Zero-length dump
      got_q.delete();
      start_dump({$urandom, $urandom}, 32'd0);
      wait_done();
      check("zero_words", got_q.size(), 0);

      // Starts while busy must be ignored
      noise_en = 1;
      got_q.delete();
      start_dump(64'h40, 32'd6);
      wait_done();
      noise_en = 0;

      // Reset while a word is being presented, then a fresh dump
      rand_ready = 0;
      stall = 3;
      start_dump(64'h100, 32'd5);
      n = 0;
      while (!io_out_valid && n < 20) begin tick(); n++; end
      apply_reset();
      got_q.delete();
      start_dump(64'h40, 32'd2);
      wait_done();
      if (got_q.size() >= 2) begin
         check("post_rst_w0", got_q[0], 32'hDEADBEEF);
         check("post_rst_w1", got_q[1], 32'h00C0FFEE);
      end else check("post_rst_count", got_q.size(), 2);

      // Random dumps with back-pressure and start noise
      rand_ready = 1;
      noise_en   = 1;
      for (int t = 0; t < 25; t++) begin
         if ((t % 5) == 0) begin
            for (int i = 0; i < 64; i++) mem_w[$urandom_range(0, DEPTH-1)] = $urandom;
         end
         start_dump({$urandom, $urandom}, 32'($urandom_range(0, 10)));
         wait_done();
      end
      noise_en = 0;
      rand_ready = 0;
      repeat (3) tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
